// File: rtl/std_div_seq.sv
// ---------------------------------------------------------------------------
// std_div_seq -- iterative restoring divider, one quotient bit per clock.
//
// A go pulse sampled in IDLE captures the operands. WIDTH restoring steps run
// in BUSY, FIX applies the sign correction and writes the registered results,
// and done pulses for exactly one cycle while the FSM sits in DONE. Results
// are held until the next FIX write. A synchronous active-high reset discards
// any in-flight operation.
//
// Parameters:
//   WIDTH   operand/result width in bits (2..64)
//   SIGNED  0 = unsigned, 1 = two's-complement truncating division
//
// Optional build macro:
//   STD_DIV_EARLY_OUT_EN  divide-by-zero and |left| < |right| finish one edge
//                         after capture instead of after WIDTH+1 edges.
//
// Ports:
//   clk            clock, rising edge
//   reset          synchronous, active-high reset
//   go             start request, sampled only in IDLE
//   left           dividend, captured on the go edge
//   right          divisor, captured on the go edge
//   out_quotient   registered quotient
//   out_remainder  registered remainder
//   done           registered one-cycle completion pulse
// ---------------------------------------------------------------------------
module std_div_seq #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement negation applied only when neg is set.
    function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                  input logic             neg);
        logic [WIDTH-1:0] res;
        if (neg) begin
            res = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            res = v;
        end
        return res;
    endfunction

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dvd;    // dividend magnitude; quotient bits shift in at the LSB
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_dsr;    // divisor magnitude
    logic [WIDTH-1:0] r_left;   // original dividend, returned on divide-by-zero
    logic             r_neg_l;
    logic             r_neg_r;
    logic             r_div0;

    logic             w_neg_l;
    logic             w_neg_r;
    logic [WIDTH-1:0] w_mag_l;
    logic [WIDTH-1:0] w_mag_r;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rem_next;
    logic             w_early;

    assign w_neg_l = SIGNED & left[WIDTH-1];
    assign w_neg_r = SIGNED & right[WIDTH-1];
    assign w_mag_l = cond_neg(left, w_neg_l);
    assign w_mag_r = cond_neg(right, w_neg_r);

    // Restoring step: the shifted remainder can never exceed twice the divisor,
    // so a clear borrow bit of the trial subtraction means "fits". A set bit in
    // the shifted value also means it fits; this only matters for robustness.
    assign w_shift    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dsr};
    assign w_qbit     = w_shift[WIDTH] | ~w_diff[WIDTH];
    assign w_rem_next = w_qbit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];

`ifdef STD_DIV_EARLY_OUT_EN
    // Trivial cases: quotient is fixed and the remainder is the dividend.
    assign w_early = (right == {WIDTH{1'b0}}) || (w_mag_l < w_mag_r);
`else
    assign w_early = 1'b0;
`endif

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= {CW{1'b0}};
            r_dvd         <= {WIDTH{1'b0}};
            r_rem         <= {WIDTH{1'b0}};
            r_dsr         <= {WIDTH{1'b0}};
            r_left        <= {WIDTH{1'b0}};
            r_neg_l       <= 1'b0;
            r_neg_r       <= 1'b0;
            r_div0        <= 1'b0;
            out_quotient  <= {WIDTH{1'b0}};
            out_remainder <= {WIDTH{1'b0}};
            done          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (go) begin
                        r_left  <= left;
                        r_neg_l <= w_neg_l;
                        r_neg_r <= w_neg_r;
                        r_div0  <= (right == {WIDTH{1'b0}});
                        r_dsr   <= w_mag_r;
                        r_cnt   <= {CW{1'b0}};
                        if (w_early) begin
                            // Preload the final quotient/remainder magnitudes and
                            // go straight to the result write; the usual sign
                            // correction then reproduces the dividend.
                            r_dvd   <= {WIDTH{1'b0}};
                            r_rem   <= w_mag_l;
                            r_state <= S_FIX;
                        end else begin
                            r_dvd   <= w_mag_l;
                            r_rem   <= {WIDTH{1'b0}};
                            r_state <= S_BUSY;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
                    r_cnt <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state <= S_BUSY;
                    end
                end
                S_FIX: begin
                    if (r_div0) begin
                        out_quotient  <= {WIDTH{1'b1}};
                        out_remainder <= r_left;
                    end else begin
                        out_quotient  <= cond_neg(r_dvd, r_neg_l ^ r_neg_r);
                        out_remainder <= cond_neg(r_rem, r_neg_l);
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_std_div_seq.sv
// ---------------------------------------------------------------------------
// Self-checking bench for std_div_seq. Three instances (8-bit unsigned,
// 8-bit signed, 32-bit unsigned) share clock and reset. An arithmetic model
// predicts done timing and held results; a negedge process compares every
// output of every instance each cycle, and directed cases pin literal values.
// ---------------------------------------------------------------------------
module tb_std_div_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        g0, g1, g2;
    logic [7:0]  a0, b0, a1, b1;
    logic [31:0] a2, b2;
    logic [7:0]  q0, m0, q1, m1;
    logic [31:0] q2, m2;
    logic        d0, d1, d2;

    std_div_seq #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .reset(reset), .go(g0), .left(a0), .right(b0),
        .out_quotient(q0), .out_remainder(m0), .done(d0));
    std_div_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .clk(clk), .reset(reset), .go(g1), .left(a1), .right(b1),
        .out_quotient(q1), .out_remainder(m1), .done(d1));
    std_div_seq #(.WIDTH(32), .SIGNED(1'b0)) u_u32 (
        .clk(clk), .reset(reset), .go(g2), .left(a2), .right(b2),
        .out_quotient(q2), .out_remainder(m2), .done(d2));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state per instance
    int              busy [3];
    bit              back [3];
    bit              edone[3];
    longint unsigned eq[3], er[3], pq[3], pr[3];

    function automatic int wof(input int k);
        return (k == 2) ? 32 : 8;
    endfunction

    function automatic bit sof(input int k);
        return (k == 1);
    endfunction

    // Reference division from the arithmetic definition.
    function automatic void ref_div(input int w, input bit s,
                                    input longint unsigned l, input longint unsigned r,
                                    output longint unsigned q, output longint unsigned rm,
                                    output bit early);
        longint unsigned mask;
        longint sl, sr, al, ar;
        mask = (64'd1 << w) - 64'd1;
        sl = longint'(l);
        sr = longint'(r);
        if (s && l[w-1]) sl = sl - (longint'(1) << w);
        if (s && r[w-1]) sr = sr - (longint'(1) << w);
        al = (sl < 0) ? -sl : sl;
        ar = (sr < 0) ? -sr : sr;
        early = (r == 64'd0) || (al < ar);
        if (r == 64'd0) begin
            q = mask; rm = l;
        end else if (s && sl == -(longint'(1) << (w - 1)) && sr == -64'sd1) begin
            q = l; rm = 64'd0;
        end else if (s) begin
            q  = longint'(sl / sr) & mask;
            rm = longint'(sl % sr) & mask;
        end else begin
            q = l / r; rm = l % r;
        end
    endfunction

    function automatic int exp_lat(input int k, input longint unsigned l, input longint unsigned r);
        longint unsigned q, rm;
        bit e;
        ref_div(wof(k), sof(k), l, r, q, rm, e);
`ifdef STD_DIV_EARLY_OUT_EN
        return e ? 1 : wof(k) + 1;
`else
        return wof(k) + 1;
`endif
    endfunction

    function automatic logic dk(input int k);
        case (k)
            0: return d0;
            1: return d1;
            default: return d2;
        endcase
    endfunction

    function automatic longint unsigned oq(input int k);
        case (k)
            0: return 64'(q0);
            1: return 64'(q1);
            default: return 64'(q2);
        endcase
    endfunction

    function automatic longint unsigned orm(input int k);
        case (k)
            0: return 64'(m0);
            1: return 64'(m1);
            default: return 64'(m2);
        endcase
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int k, input logic g, input longint unsigned a, input longint unsigned b);
        case (k)
            0: begin g0 = g; a0 = a[7:0];  b0 = b[7:0];  end
            1: begin g1 = g; a1 = a[7:0];  b1 = b[7:0];  end
            default: begin g2 = g; a2 = a[31:0]; b2 = b[31:0]; end
        endcase
    endtask

    // Model step: an accepted request yields one done pulse after its latency,
    // followed by one cycle during which a new request is not accepted.
    task automatic mstep(input int k, input logic g, input longint unsigned l, input longint unsigned r);
        bit e;
        if (reset) begin
            busy[k] = 0; back[k] = 1'b0; edone[k] = 1'b0; eq[k] = 64'd0; er[k] = 64'd0;
        end else begin
            edone[k] = 1'b0;
            if (busy[k] > 0) begin
                busy[k]--;
                if (busy[k] == 0) begin
                    eq[k] = pq[k]; er[k] = pr[k]; edone[k] = 1'b1; back[k] = 1'b1;
                end
            end else if (back[k]) begin
                back[k] = 1'b0;
            end else if (g) begin
                ref_div(wof(k), sof(k), l, r, pq[k], pr[k], e);
                busy[k] = exp_lat(k, l, r);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        mstep(0, g0, 64'(a0), 64'(b0));
        mstep(1, g1, 64'(a1), 64'(b1));
        mstep(2, g2, 64'(a2), 64'(b2));
    end

    // Compare every output of every instance against the model each cycle.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("done%0d", k), 64'(dk(k)), 64'(edone[k]));
                check($sformatf("quot%0d", k), oq(k), eq[k]);
                check($sformatf("rem%0d", k), orm(k), er[k]);
            end
        end
    end

    // One operation: go held for `hold` cycles, optional operand scramble
    // after capture, returns edges from the sampling edge to done.
    task automatic run_op(input int k, input longint unsigned a, input longint unsigned b,
                          input int hold, input bit scr, output int lat,
                          output longint unsigned q, output longint unsigned r);
        int  c;
        bit  got;
        longint unsigned ca, cb;
        repeat (2) @(negedge clk);
        ca = a; cb = b;
        drive(k, 1'b1, ca, cb);
        c = 0; got = 1'b0;
        while (!got && c < 80) begin
            @(negedge clk);
            c++;
            if (scr && c == 2) begin
                ca = {$urandom, $urandom}; cb = {$urandom, $urandom};
            end
            drive(k, c < hold, ca, cb);
            got = dk(k);
        end
        drive(k, 1'b0, ca, cb);
        if (!got) begin
            total++; bad++;
            $display("FAIL timeout k=%0d: got no done want done within 80 cycles", k);
        end
        lat = c - 1;
        q = oq(k); r = orm(k);
    endtask

    function automatic longint unsigned pick(input int w);
        longint unsigned mask;
        mask = (64'd1 << w) - 64'd1;
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return mask;
            2: return 64'd1 << (w - 1);
            3: return 64'd1;
            default: return 64'($urandom) & mask;
        endcase
    endfunction

    initial begin
        int lat, c, k, w;
        bit got, e;
        longint unsigned q, r, xq, xr;

        reset = 1'b1;
        g0 = 1'b0; g1 = 1'b0; g2 = 1'b0;
        a0 = 8'd0; b0 = 8'd0; a1 = 8'd0; b1 = 8'd0; a2 = 32'd0; b2 = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_q0", 64'(q0), 64'd0);
        check("rst_m2", 64'(m2), 64'd0);
        check("rst_d1", 64'(d1), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // pin the model itself
        ref_div(8, 1'b1, 64'hF9, 64'h02, xq, xr, e);
        check("pin_s_q", xq, 64'hFD); check("pin_s_r", xr, 64'hFF);
        ref_div(8, 1'b1, 64'h07, 64'hFE, xq, xr, e);
        check("pin_s2_q", xq, 64'hFD); check("pin_s2_r", xr, 64'h01);

        // 200/7 unsigned, then hold for 5 idle cycles
        run_op(0, 64'd200, 64'd7, 1, 1'b0, lat, q, r);
        check("u8_lat", 64'(lat), 64'd9);
        check("u8_q", q, 64'd28); check("u8_r", r, 64'd4);
        repeat (5) @(negedge clk);
        check("u8_hold_q", 64'(q0), 64'd28); check("u8_hold_r", 64'(m0), 64'd4);

        // divide by zero
        run_op(0, 64'd13, 64'd0, 1, 1'b0, lat, q, r);
`ifdef STD_DIV_EARLY_OUT_EN
        check("dz_lat", 64'(lat), 64'd1);
`else
        check("dz_lat", 64'(lat), 64'd9);
`endif
        check("dz_q", q, 64'hFF); check("dz_r", r, 64'd13);

        // signed cases
        run_op(1, 64'hF9, 64'h02, 1, 1'b0, lat, q, r);
        check("s_m7d2_q", q, 64'hFD); check("s_m7d2_r", r, 64'hFF);
        run_op(1, 64'h07, 64'hFE, 1, 1'b0, lat, q, r);
        check("s_7dm2_q", q, 64'hFD); check("s_7dm2_r", r, 64'h01);
        run_op(1, 64'h80, 64'hFF, 1, 1'b0, lat, q, r);
        check("s_ovf_q", q, 64'h80); check("s_ovf_r", r, 64'h00);
        check("s_ovf_lat", 64'(lat), 64'd9);

        // go held high: back-to-back operations
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 64'd100, 64'd9);
        c = 0; got = 1'b0;
        while (!got && c < 40) begin @(negedge clk); c++; got = d0; end
        check("held1_lat", 64'(c - 1), 64'd9);
        check("held1_q", 64'(q0), 64'd11); check("held1_r", 64'(m0), 64'd1);
        drive(0, 1'b1, 64'd50, 64'd5);
        c = 0; got = 1'b0;
        while (!got && c < 40) begin @(negedge clk); c++; got = d0; end
        check("held_spacing", 64'(c), 64'd11);
        check("held2_q", 64'(q0), 64'd10); check("held2_r", 64'(m0), 64'd0);
        drive(0, 1'b0, 64'd50, 64'd5);

        // reset in the middle of an operation
        repeat (2) @(negedge clk);
        drive(0, 1'b1, 64'd200, 64'd7);
        @(negedge clk);
        drive(0, 1'b0, 64'd200, 64'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            check("rst_mid_done", 64'(d0), 64'd0);
            check("rst_mid_q", 64'(q0), 64'd0);
            @(negedge clk);
        end
        run_op(0, 64'd9, 64'd3, 1, 1'b0, lat, q, r);
        check("post_rst_lat", 64'(lat), 64'd9);
        check("post_rst_q", q, 64'd3); check("post_rst_r", r, 64'd0);

        // 32-bit with operand changes during BUSY
        run_op(2, 64'hFFFF_FFFF, 64'h1_0000, 1, 1'b1, lat, q, r);
        check("u32_lat", 64'(lat), 64'd33);
        check("u32_q", q, 64'hFFFF); check("u32_r", r, 64'hFFFF);

        // randomized operations against the model
        for (int i = 0; i < 120; i++) begin
            k = $urandom_range(0, 2);
            w = wof(k);
            xq = pick(w); xr = pick(w);
            run_op(k, xq, xr, $urandom_range(1, 3), 1'($urandom_range(0, 1)), lat, q, r);
            check($sformatf("rnd_lat%0d", k), 64'(lat), 64'(exp_lat(k, xq, xr)));
            ref_div(w, sof(k), xq, xr, xq, xr, e);
            check($sformatf("rnd_q%0d", k), q, xq);
            check($sformatf("rnd_r%0d", k), r, xr);
        end

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
